// File: rtl/mips_mem_pkg.sv
// Shared constants and loader state encoding for the MIPS memory responder.
// Imported by the interface, the loader and the top.
package mips_mem_pkg;

    localparam int DEF_DEPTH  = 128;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_COLLECT,
        LD_COMMIT
    } ld_state_t;

endpackage

// File: rtl/mips_mem_responder_if.sv
// CPU access and program-loader signal bundle for mips_mem_responder.
// master: CPU/loader side (CS, WE, ADDR, LD_*); slave: the memory block.
interface mips_mem_responder_if #(
    parameter int ADDR_W = mips_mem_pkg::DEF_ADDR_W
);
    logic              CS;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic              LD_EN;
    logic              LD_VALID;
    logic [7:0]        LD_BYTE;
    logic              LD_READY;
    logic              CPU_HOLD;
    logic [7:0]        LD_WORDS;
    logic              COLLIDE;

    modport master (
        output CS, WE, ADDR,
        output LD_EN, LD_VALID, LD_BYTE,
        input  LD_READY, CPU_HOLD,
        input  LD_WORDS, COLLIDE
    );

    modport slave (
        input  CS, WE, ADDR,
        input  LD_EN, LD_VALID, LD_BYTE,
        output LD_READY, CPU_HOLD,
        output LD_WORDS, COLLIDE
    );

endinterface

// File: rtl/mips_mem_loader.sv
// Program loader: assembles little-endian bytes into words and commits them.
// Ports: i_en/i_valid/i_byte in, o_ready/o_hold/o_words status, o_wr/o_addr/o_word.
module mips_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_ready,
    output logic              o_hold,
    output logic [7:0]        o_words,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_word
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        MAX_WORDS = 8'(DEPTH);

    ld_state_t         r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_words;
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LD_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_words <= '0;
            r_word  <= '0;
        end else begin
            unique case (r_state)
                LD_IDLE: begin
                    if (i_en) begin
                        r_state <= LD_COLLECT;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_words <= '0;
                    end
                end
                LD_COLLECT: begin
                    // Dropping enable abandons any partial word.
                    if (!i_en) begin
                        r_state <= LD_IDLE;
                        r_cnt   <= '0;
                    end else if (i_valid) begin
                        r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= LD_COMMIT;
                        end
                    end
                end
                LD_COMMIT: begin
                    // The array writes r_word at r_addr on this edge.
                    if (r_addr == LAST_ADDR) begin
                        r_addr <= '0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if (r_words != MAX_WORDS) begin
                        r_words <= r_words + 8'd1;
                    end
                    r_state <= i_en ? LD_COLLECT : LD_IDLE;
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == LD_COLLECT) && i_en;
    assign o_hold  = i_en || (r_state != LD_IDLE);
    assign o_words = r_words;
    assign o_wr    = (r_state == LD_COMMIT);
    assign o_addr  = r_addr;
    assign o_word  = r_word;

endmodule

// File: rtl/mips_mem_responder.sv
// Word memory shared by a CPU bus (tri-state Mem_Bus) and a byte loader.
// Ports: CLK, RST (async low), Mem_Bus inout, bus_if slave bundle.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                CLK,
    input  logic                RST,
    inout  wire  [DATA_W-1:0]   Mem_Bus,
    mips_mem_responder_if.slave bus_if
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_collide;

    logic              w_ld_wr;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [DATA_W-1:0] w_ld_word;
    logic              w_hold;
    logic              w_ready;
    logic [7:0]        w_words;
    logic              w_rd_en;
    logic              w_cpu_try;
    logic              w_cpu_wr;

    mips_mem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_en    (bus_if.LD_EN),
        .i_valid (bus_if.LD_VALID),
        .i_byte  (bus_if.LD_BYTE),
        .o_ready (w_ready),
        .o_hold  (w_hold),
        .o_words (w_words),
        .o_wr    (w_ld_wr),
        .o_addr  (w_ld_addr),
        .o_word  (w_ld_word)
    );

    assign bus_if.LD_READY = w_ready;
    assign bus_if.CPU_HOLD = w_hold;
    assign bus_if.LD_WORDS = w_words;
    assign bus_if.COLLIDE  = r_collide;

    assign w_cpu_try = RST && bus_if.CS && bus_if.WE;
    assign w_cpu_wr  = w_cpu_try && !w_hold;

    // WE=1 is excluded so the CPU never fights us on a write.
    assign w_rd_en = RST && bus_if.CS && !bus_if.WE && !w_hold;
    assign Mem_Bus = w_rd_en ? r_mem[bus_if.ADDR] : 'z;

    // Storage is deliberately not reset so contents survive RST.
    always_ff @(posedge CLK) begin
        if (w_ld_wr) begin
            r_mem[w_ld_addr] <= w_ld_word;
        end else if (w_cpu_wr) begin
            r_mem[bus_if.ADDR] <= Mem_Bus;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_collide <= 1'b0;
        end else if (w_cpu_try && w_hold) begin
            r_collide <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: vector table plus
// loader/collision/reset sequences with a read scoreboard.
module tb_mips_mem_responder;
    import mips_mem_pkg::*;

    localparam logic [31:0] ZV = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [6:0]  addr;
        logic        drv;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        tb_oe  = 1'b0;
    logic [31:0] tb_dat = '0;
    wire  [31:0] bus;

    assign bus = tb_oe ? tb_dat : 32'hz;
    pullup pu (bus);

    mips_mem_responder_if #(.ADDR_W(7)) bif ();

    mips_mem_responder #(
        .DEPTH  (128),
        .ADDR_W (7),
        .DATA_W (32)
    ) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .Mem_Bus (bus),
        .bus_if  (bif)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m [128];
    int          ma = 0;
    int          mw = 0;
    logic [31:0] sbq [$];
    vec_t        tv [12];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            chk(nm, bus, sbq.pop_front());
        end
    endtask

    task automatic cpu_read(input string nm, input logic [6:0] a);
        @(negedge clk);
        bif.CS   = 1'b1;
        bif.WE   = 1'b0;
        bif.ADDR = a;
        sbq.push_back(m[a]);
        #1;
        sb_check(nm);
        bif.CS = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        bif.LD_VALID = 1'b1;
        bif.LD_BYTE  = b;
        #1;
        t = 0;
        while (!bif.LD_READY && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ld_ready_timeout: got 0, expected 1");
        end
        chk("cpu_hold_load", 32'(bif.CPU_HOLD), 32'd1);
        @(posedge clk);
        #1;
        bif.LD_VALID = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
        m[ma] = w;
        ma = (ma + 1) % 128;
        if (mw < 128) mw++;
    endtask

    task automatic ld_start();
        @(negedge clk);
        bif.LD_EN = 1'b1;
        @(negedge clk);
        ma = 0;
        mw = 0;
        chk("ld_words_clear", 32'(bif.LD_WORDS), 32'd0);
    endtask

    task automatic ld_stop();
        @(negedge clk);
        bif.LD_EN = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_idle", 32'(bif.CPU_HOLD), 32'd0);
        chk("ld_words", 32'(bif.LD_WORDS), 32'(mw));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.CS       = 1'b1;
        bif.WE       = 1'b0;
        bif.ADDR     = '0;
        bif.LD_EN    = 1'b0;
        bif.LD_VALID = 1'b0;
        bif.LD_BYTE  = '0;

        // Reset state, including bus released despite a CPU read.
        #2;
        chk("rst_ready", 32'(bif.LD_READY), 32'd0);
        chk("rst_hold", 32'(bif.CPU_HOLD), 32'd0);
        chk("rst_words", 32'(bif.LD_WORDS), 32'd0);
        chk("rst_collide", 32'(bif.COLLIDE), 32'd0);
        chk("rst_bus_z", bus, ZV);
        bif.CS    = 1'b0;
        bif.LD_EN = 1'b1;
        #1;
        chk("rst_hold_en", 32'(bif.CPU_HOLD), 32'd1);
        chk("rst_ready_en", 32'(bif.LD_READY), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bif.LD_READY), 32'd0);
        @(negedge clk);
        #1;
        chk("collect_ready", 32'(bif.LD_READY), 32'd1);

        // Two-word load; enable drops during the final commit.
        ma = 0;
        mw = 0;
        load_word(32'h1234_5678);
        load_word(32'hDEAD_BEEF);
        ld_stop();

        tv[0]  = '{1'b1, 1'b0, 7'd1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        tv[1]  = '{1'b0, 1'b0, 7'd1, 1'b0, 32'h0, 1'b1, ZV};
        tv[2]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0, 1'b1, 32'h1234_5678};
        tv[3]  = '{1'b1, 1'b1, 7'd5, 1'b1, 32'hAA, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 1'b0, 7'd5, 1'b0, 32'h0, 1'b1, 32'hAA};
        tv[5]  = '{1'b1, 1'b1, 7'd1, 1'b0, 32'h0, 1'b1, ZV};
        tv[6]  = '{1'b1, 1'b1, 7'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b0, 7'd1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        tv[8]  = '{1'b1, 1'b1, 7'd3, 1'b1, 32'h3333_3333, 1'b0, 32'h0};
        tv[9]  = '{1'b1, 1'b0, 7'd3, 1'b0, 32'h0, 1'b1, 32'h3333_3333};
        tv[10] = '{1'b0, 1'b1, 7'd3, 1'b1, 32'h0, 1'b0, 32'h0};
        tv[11] = '{1'b1, 1'b0, 7'd3, 1'b0, 32'h0, 1'b1, 32'h3333_3333};

        foreach (tv[i]) begin
            @(negedge clk);
            bif.CS   = tv[i].cs;
            bif.WE   = tv[i].we;
            bif.ADDR = tv[i].addr;
            tb_oe    = tv[i].drv;
            tb_dat   = tv[i].wd;
            if (tv[i].chk) sbq.push_back(tv[i].exp);
            #1;
            if (tv[i].chk) sb_check($sformatf("vec%0d", i));
            if (tv[i].cs && tv[i].we) begin
                m[tv[i].addr] = tv[i].drv ? tv[i].wd : ZV;
            end
            @(posedge clk);
            #1;
            tb_oe  = 1'b0;
            bif.CS = 1'b0;
            bif.WE = 1'b0;
        end

        // Partial word abandoned, then a fresh load restarts at 0.
        ld_start();
        send_byte(8'h11);
        send_byte(8'h22);
        ld_stop();
        cpu_read("partial_keep", 7'd0);
        ld_start();
        load_word(32'hCAFE_F00D);
        ld_stop();
        cpu_read("restart_mem0", 7'd0);

        // Blocked CPU access while held, then reset mid-word.
        ld_start();
        @(negedge clk);
        bif.CS   = 1'b1;
        bif.WE   = 1'b0;
        bif.ADDR = 7'd0;
        sbq.push_back(ZV);
        #1;
        sb_check("hold_read_z");
        bif.WE   = 1'b1;
        bif.ADDR = 7'd3;
        tb_oe    = 1'b1;
        tb_dat   = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        chk("collide_set", 32'(bif.COLLIDE), 32'd1);
        tb_oe  = 1'b0;
        bif.CS = 1'b0;
        bif.WE = 1'b0;
        load_word(32'h5A5A_5A5A);
        send_byte(8'h99);
        send_byte(8'h88);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_collide", 32'(bif.COLLIDE), 32'd0);
        chk("midrst_ready", 32'(bif.LD_READY), 32'd0);
        chk("midrst_words", 32'(bif.LD_WORDS), 32'd0);
        chk("midrst_hold", 32'(bif.CPU_HOLD), 32'd1);
        bif.LD_EN = 1'b0;
        #1;
        chk("midrst_hold_off", 32'(bif.CPU_HOLD), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read("collide_mem3", 7'd3);
        cpu_read("rst_keep_mem0", 7'd0);

        // 129 words: the last wraps onto address 0, count saturates.
        ld_start();
        for (int i = 0; i < 129; i++) begin
            load_word(32'h1000_0000 + 32'(i));
        end
        ld_stop();
        chk("wrap_words", 32'(bif.LD_WORDS), 32'd128);
        cpu_read("wrap_mem0", 7'd0);
        cpu_read("wrap_mem1", 7'd1);
        cpu_read("wrap_mem127", 7'd127);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
